apb_pwm_bank: RTL

//   APB2 slave (EMPU peripheral slot) driving N_CH complementary PWM channel pairs for BLDC gate drive.

---
 rtl/apb_pwm_bank.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/apb_pwm_bank.sv
// APB2 slave driving N_CH complementary PWM pairs with a shared edge/centre-aligned
// timebase, double-buffered period/duty and per-channel dead-time insertion.
module apb_pwm_bank #(
  parameter int unsigned N_CH  = 3,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DT_W  = 8
) (
  input  logic            sys_clk,
  input  logic            reset_n,
  input  logic            psel,
  input  logic            penable,
  input  logic [7:0]      paddr,
  input  logic            pwrite,
  input  logic [31:0]     pwdata,
  input  logic [3:0]      pstrb,
  output logic [31:0]     prdata,
  output logic            pready,
  output logic            pslverr,
  output logic [N_CH-1:0] pwm_h,
  output logic [N_CH-1:0] pwm_l,
  output logic            irq
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic             en, mode, irq_en, upd, mode_a;
  logic [CNT_W-1:0] period, period_a, cnt, duty_rd;
  logic [DT_W-1:0]  deadtime;
  logic [CNT_W-1:0] duty   [N_CH];
  logic [CNT_W-1:0] duty_a [N_CH];
  logic [DT_W-1:0]  dtc    [N_CH];
  logic [N_CH-1:0]  raw, raw_q;
  dir_t             dir;

  logic        setup, wr_acc, mapped, duty_hit;
  logic        sel_ctrl, sel_period, sel_dt, sel_status, sel_cnt;
  logic        wr_ctrl, wr_period, wr_dt, wr_duty, w1c, force_upd;
  logic        en_nxt, mode_nxt, en_rise, reload_ev, load_a;
  logic [2:0]  duty_idx;
  logic [31:0] rd_val, ctrl_w, period_w, dt_w, duty_w;
  logic        unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int unsigned b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  assign pready = 1'b1;
  assign irq    = upd & irq_en;

  assign setup      = psel & ~penable;
  assign wr_acc     = psel & penable & pwrite;
  assign sel_ctrl   = (paddr == 8'h00);
  assign sel_period = (paddr == 8'h04);
  assign sel_dt     = (paddr == 8'h08);
  assign sel_status = (paddr == 8'h0C);
  assign sel_cnt    = (paddr == 8'h10);
  assign duty_idx   = paddr[4:2];
  assign duty_hit   = (paddr[7:5] == 3'b001) && (paddr[1:0] == 2'b00) && (32'(duty_idx) < N_CH);
  assign mapped     = sel_ctrl | sel_period | sel_dt | sel_status | sel_cnt | duty_hit;

  assign wr_ctrl   = wr_acc & sel_ctrl;
  assign wr_period = wr_acc & sel_period;
  assign wr_dt     = wr_acc & sel_dt;
  assign wr_duty   = wr_acc & duty_hit;
  assign w1c       = wr_acc & sel_status & pstrb[0] & pwdata[0];
  assign force_upd = wr_ctrl & pstrb[0] & pwdata[3];

  assign ctrl_w   = merge({29'b0, irq_en, mode, en}, pwdata, pstrb);
  assign period_w = merge(32'(period), pwdata, pstrb);
  assign dt_w     = merge(32'(deadtime), pwdata, pstrb);
  assign duty_w   = merge(32'(duty_rd), pwdata, pstrb);
  // Upper merge bits beyond the field widths are intentionally discarded.
  assign unused_bits = ^{ctrl_w[31:3], period_w, dt_w, duty_w};

  always_comb begin
    duty_rd = '0;
    for (int unsigned i = 0; i < N_CH; i++)
      if (duty_idx == 3'(i)) duty_rd = duty[i];
  end

  always_comb begin
    rd_val = '0;
    if (sel_ctrl)   rd_val = {29'b0, irq_en, mode, en};
    if (sel_period) rd_val = 32'(period);
    if (sel_dt)     rd_val = 32'(deadtime);
    if (sel_status) rd_val = {31'b0, upd};
    if (sel_cnt)    rd_val = 32'(cnt);
    if (duty_hit)   rd_val = 32'(duty_rd);
  end

  // Disable acts on the same edge that commits EN=0, so the next cycle is already idle.
  assign en_nxt    = wr_ctrl ? ctrl_w[0] : en;
  assign mode_nxt  = wr_ctrl ? ctrl_w[1] : mode;
  assign en_rise   = ~en & en_nxt;
  assign reload_ev = en & en_nxt & ((period_a == '0) ||
                     (!mode_a && (cnt >= period_a)) ||
                     (mode_a && (dir == DIR_DOWN) && (cnt == '0)));
  assign load_a    = reload_ev | en_rise | force_upd;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      en <= 1'b0; mode <= 1'b0; irq_en <= 1'b0; upd <= 1'b0;
      period <= '0; deadtime <= '0; prdata <= '0; pslverr <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) duty[i] <= '0;
    end else begin
      if (setup) begin
        prdata  <= rd_val;
        pslverr <= ~mapped;
      end
      if (wr_ctrl) begin
        en     <= ctrl_w[0];
        mode   <= ctrl_w[1];
        irq_en <= ctrl_w[2];
      end
      if (wr_period) period   <= period_w[CNT_W-1:0];
      if (wr_dt)     deadtime <= dt_w[DT_W-1:0];
      for (int unsigned i = 0; i < N_CH; i++)
        if (wr_duty && (duty_idx == 3'(i))) duty[i] <= duty_w[CNT_W-1:0];
      if (reload_ev | force_upd) upd <= 1'b1;
      else if (w1c)              upd <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0; dir <= DIR_UP; period_a <= '0; mode_a <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) duty_a[i] <= '0;
    end else begin
      if (load_a) begin
        period_a <= period;
        mode_a   <= mode_nxt;
        for (int unsigned i = 0; i < N_CH; i++) duty_a[i] <= duty[i];
      end
      if (!en_nxt || !en) begin
        cnt <= '0;
        dir <= DIR_UP;
      end else if (period_a == '0) begin
        cnt <= '0;
        dir <= DIR_UP;
      end else if (!mode_a) begin
        cnt <= (cnt >= period_a) ? '0 : cnt + CNT_W'(1);
        dir <= DIR_UP;
      end else if (dir == DIR_UP) begin
        if (cnt >= period_a) begin
          cnt <= cnt - CNT_W'(1);
          dir <= DIR_DOWN;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (cnt == '0) begin
        // Zero is the reload point; it is spent here, so restart the up-slope at 1.
        cnt <= (period == '0) ? '0 : CNT_W'(1);
        dir <= DIR_UP;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < N_CH; i++) raw[i] = (cnt < duty_a[i]);
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_h <= '0; pwm_l <= '0; raw_q <= '0;
      for (int unsigned i = 0; i < N_CH; i++) dtc[i] <= '0;
    end else if (!en || !en_nxt) begin
      pwm_h <= '0; pwm_l <= '0; raw_q <= '0;
      for (int unsigned i = 0; i < N_CH; i++) dtc[i] <= '0;
    end else begin
      raw_q <= raw;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (raw[i] != raw_q[i]) begin
          // Any edge restarts the dead-time window, cancelling a pending assertion.
          pwm_h[i] <= (deadtime == '0) ? raw[i] : 1'b0;
          pwm_l[i] <= (deadtime == '0) ? ~raw[i] : 1'b0;
          dtc[i]   <= deadtime;
        end else if (dtc[i] > DT_W'(1)) begin
          dtc[i] <= dtc[i] - DT_W'(1);
        end else begin
          dtc[i]   <= '0;
          pwm_h[i] <= raw[i];
          pwm_l[i] <= ~raw[i];
        end
      end
    end
  end

endmodule
